uart_rx_v2: RTL and testbench



---
 rtl/uart_rx_v2.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_v2.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_v2.sv
// Parametrised UART receiver with synchroniser, parity/frame/break detection and a
// one-entry valid/ready holding register. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx_v2 #(
    parameter int SystemClockFreq = 50_000_000,
    parameter int BaudRate        = 115200,
    parameter int DataLength      = 8,
    parameter int ParityEn        = 0,
    parameter int ParityEven      = 0,
    parameter int StopBits        = 1,
    parameter int SyncStages      = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rx,
    output logic [DataLength-1:0] o_rx_data,
    output logic                  o_rx_valid,
    input  logic                  i_rx_ready,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_overrun_err,
    output logic                  o_break,
    output logic                  o_busy
);
    localparam int CyclesPerBit = SystemClockFreq / BaudRate;
    localparam int Half         = CyclesPerBit / 2;
    localparam int CntW         = $clog2(CyclesPerBit);
`ifdef UART_RX_MAJORITY_EN
    localparam int DecideAt     = Half + 1;
`else
    localparam int DecideAt     = Half;
`endif
    localparam logic [CntW-1:0] CntMax   = CntW'(CyclesPerBit - 1);
    localparam logic [CntW-1:0] CntDec   = CntW'(DecideAt);
    localparam logic [3:0]      LastData = 4'(DataLength - 1);
    localparam logic [3:0]      LastStop = 4'(StopBits - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    logic [SyncStages-1:0] sync_reg;
    logic                  rx_s;
    state_t                state_reg, state_next;
    logic [CntW-1:0]       clk_cnt_reg, clk_cnt_next;
    logic [3:0]            bit_cnt_reg, bit_cnt_next;
    logic [DataLength-1:0] shift_reg, shift_next;
    logic                  perr_reg, perr_next;
    logic                  ferr_reg, ferr_next;
    logic                  par_bit_reg, par_bit_next;
    logic                  sample_tick, bit_val, ferr_final, exp_par;
    logic                  deliver, brk_det, handshake;
    logic [DataLength-1:0] data_reg;
    logic                  valid_reg, perr_out_reg, ferr_out_reg, overrun_reg, break_reg;

    assign rx_s        = sync_reg[SyncStages-1];
    assign sample_tick = (clk_cnt_reg == CntDec);

`ifdef UART_RX_MAJORITY_EN
    logic samp_a_reg, samp_b_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            samp_a_reg <= 1'b1;
            samp_b_reg <= 1'b1;
        end else begin
            if (clk_cnt_reg == CntW'(Half - 1)) samp_a_reg <= rx_s;
            if (clk_cnt_reg == CntW'(Half))     samp_b_reg <= rx_s;
        end
    end

    assign bit_val = (samp_a_reg & samp_b_reg) | (samp_a_reg & rx_s) | (samp_b_reg & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_reg    <= '1;
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            par_bit_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[SyncStages-2:0], i_rx};
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
            par_bit_reg <= par_bit_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = (clk_cnt_reg == CntMax) ? '0 : clk_cnt_reg + 1'b1;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        perr_next    = perr_reg;
        ferr_next    = ferr_reg;
        par_bit_next = par_bit_reg;
        deliver      = 1'b0;
        brk_det      = 1'b0;
        ferr_final   = ferr_reg | ~bit_val;
        exp_par      = (ParityEven != 0) ? ^shift_reg : ~^shift_reg;
        case (state_reg)
            IDLE: begin
                // Per-frame state is cleared here so each frame starts clean.
                clk_cnt_next = '0;
                bit_cnt_next = '0;
                perr_next    = 1'b0;
                ferr_next    = 1'b0;
                par_bit_next = 1'b0;
                if (!rx_s) state_next = START;
            end
            START: begin
                if (sample_tick) state_next = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (sample_tick) begin
                    shift_next   = {bit_val, shift_reg[DataLength-1:1]};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == LastData) begin
                        bit_cnt_next = '0;
                        state_next   = (ParityEn != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (sample_tick) begin
                    par_bit_next = bit_val;
                    perr_next    = (bit_val != exp_par);
                    state_next   = STOP;
                end
            end
            STOP: begin
                if (sample_tick) begin
                    ferr_next    = ferr_final;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == LastStop) begin
                        // Frame ends at the last stop sample, not at the end of its bit period.
                        if (shift_reg == '0 && !par_bit_reg && ferr_final) begin
                            brk_det    = 1'b1;
                            state_next = WAIT_IDLE;
                        end else begin
                            deliver    = 1'b1;
                            state_next = ferr_final ? WAIT_IDLE : IDLE;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign handshake = valid_reg & i_rx_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            perr_out_reg <= 1'b0;
            ferr_out_reg <= 1'b0;
            overrun_reg  <= 1'b0;
            break_reg    <= 1'b0;
        end else begin
            break_reg <= brk_det;
            if (deliver) begin
                if (!valid_reg || handshake) begin
                    data_reg     <= shift_reg;
                    perr_out_reg <= perr_reg;
                    ferr_out_reg <= ferr_final;
                    valid_reg    <= 1'b1;
                end else begin
                    overrun_reg  <= 1'b1;
                end
            end else if (handshake) begin
                valid_reg   <= 1'b0;
                overrun_reg <= 1'b0;
            end
        end
    end

    assign o_rx_data     = data_reg;
    assign o_rx_valid    = valid_reg;
    assign o_parity_err  = perr_out_reg;
    assign o_frame_err   = ferr_out_reg;
    assign o_overrun_err = overrun_reg;
    assign o_break       = break_reg;
    assign o_busy        = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_rx_v2.sv
// Directed bench for uart_rx_v2: a default-config instance and an even-parity,
// two-stop-bit instance, each checked against a scoreboard of expected words.
module tb_uart_rx_v2;
    localparam int CPB1  = 434;
    localparam int HALF1 = CPB1 / 2;
    localparam int CPB2  = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rx1, rx2, ready1, ready2;
    logic [7:0] data1, data2;
    logic       valid1, perr1, ferr1, ovr1, brk1, busy1;
    logic       valid2, perr2, ferr2, ovr2, brk2, busy2;

    uart_rx_v2 dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx1),
        .o_rx_data(data1), .o_rx_valid(valid1), .i_rx_ready(ready1),
        .o_parity_err(perr1), .o_frame_err(ferr1), .o_overrun_err(ovr1),
        .o_break(brk1), .o_busy(busy1)
    );

    uart_rx_v2 #(
        .SystemClockFreq(1_600_000), .BaudRate(100_000), .DataLength(8),
        .ParityEn(1), .ParityEven(1), .StopBits(2), .SyncStages(2)
    ) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx2),
        .o_rx_data(data2), .o_rx_valid(valid2), .i_rx_ready(ready2),
        .o_parity_err(perr2), .o_frame_err(ferr2), .o_overrun_err(ovr2),
        .o_break(brk2), .o_busy(busy2)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t q1[$];
    exp_t q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Monitors: pop the scoreboard on each handshake; track pulse timing on dut1.
    int   rise_cyc1 = 0, run1 = 0, len1 = 0, brk_cnt1 = 0, brk_cnt2 = 0;
    logic vprev1 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (valid1 && !vprev1) begin
            rise_cyc1 = cyc;
            run1      = 0;
        end
        if (valid1) run1++;
        else if (vprev1) len1 = run1;
        vprev1 = valid1;
        if (brk1) brk_cnt1++;
        if (brk2) brk_cnt2++;
        if (valid1 && ready1) begin
            tests++;
            assert (q1.size() != 0) else begin
                fails++;
                $error("FAIL dut1_unexpected_word observed=0x%0h expected=none", data1);
            end
            if (q1.size() != 0) begin
                e = q1.pop_front();
                $display("[TB] dut1 word 0x%0h perr=%0b ferr=%0b", data1, perr1, ferr1);
                check("dut1_data", data1, e.data);
                check("dut1_perr", perr1, e.perr);
                check("dut1_ferr", ferr1, e.ferr);
            end
        end
        if (valid2 && ready2) begin
            tests++;
            assert (q2.size() != 0) else begin
                fails++;
                $error("FAIL dut2_unexpected_word observed=0x%0h expected=none", data2);
            end
            if (q2.size() != 0) begin
                e = q2.pop_front();
                $display("[TB] dut2 word 0x%0h perr=%0b ferr=%0b", data2, perr2, ferr2);
                check("dut2_data", data2, e.data);
                check("dut2_perr", perr2, e.perr);
                check("dut2_ferr", ferr2, e.ferr);
            end
        end
    end

    task automatic send(input int sel, input logic [15:0] vec, input int n, input int cpb);
        for (int i = 0; i < n; i++) begin
            if (sel == 1) rx1 = vec[i];
            else          rx2 = vec[i];
            repeat (cpb) @(posedge clk);
            #1;
        end
    endtask

    task automatic send1(input logic [7:0] d, input logic stop);
        send(1, {6'b0, stop, d, 1'b0}, 10, CPB1);
    endtask

    task automatic send2(input logic [7:0] d, input logic par, input logic s1, input logic s2);
        send(2, {4'b0, s2, s1, par, d, 1'b0}, 12, CPB2);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int start;
        int b0;
        rst_n  = 1'b0;
        rx1    = 1'b1;
        rx2    = 1'b1;
        ready1 = 1'b1;
        ready2 = 1'b1;
        wait_cycles(5);
        check("reset_outputs1", {data1, valid1, perr1, ferr1, ovr1, brk1, busy1}, 32'd0);
        check("reset_outputs2", {data2, valid2, perr2, ferr2, ovr2, brk2, busy2}, 32'd0);
        rst_n = 1'b1;
        wait_cycles(5);

        // Basic frame with latency and single-cycle valid pulse.
        start = cyc;
        q1.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0});
        send1(8'hA5, 1'b1);
        check("a5_latency", rise_cyc1, start + 4 + HALF1 + 9 * CPB1 + MAJ);
        check("a5_valid_len", len1, 1);
        check("a5_q_empty", q1.size(), 0);
        wait_cycles(2 * CPB1);

        // False start: low for 100 cycles only.
        start = cyc;
        rx1 = 1'b0;
        wait_cycles(50);
        check("fs_busy_high", busy1, 1);
        wait_cycles(50);
        rx1 = 1'b1;
        wait_until(start + 3 + HALF1 + MAJ);
        check("fs_busy_before_sample", busy1, 1);
        wait_until(start + 4 + HALF1 + MAJ);
        check("fs_busy_after_sample", busy1, 0);
        wait_cycles(CPB1);
        check("fs_no_flags", {valid1, perr1, ferr1, ovr1, brk_cnt1[0]}, 0);

        // Framing error, then a break, then recovery.
        q1.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b1});
        send1(8'h55, 1'b0);
        rx1 = 1'b1;
        wait_cycles(2 * CPB1);
        check("ferr_q_empty", q1.size(), 0);
        b0  = brk_cnt1;
        rx1 = 1'b0;
        wait_cycles(20 * CPB1);
        check("break_busy_while_low", busy1, 1);
        rx1 = 1'b1;
        wait_cycles(2 * CPB1);
        $display("[TB] dut1 break pulses %0d", brk_cnt1 - b0);
        check("break_one_pulse", brk_cnt1 - b0, 1);
        check("break_busy_after", busy1, 0);
        q1.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
        send1(8'h3C, 1'b1);
        wait_cycles(2 * CPB1);
        check("3c_q_empty", q1.size(), 0);

        // Overrun with back-to-back frames while the consumer stalls.
        ready1 = 1'b0;
        q1.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0});
        send1(8'h11, 1'b1);
        send1(8'h22, 1'b1);
        wait_cycles(CPB1);
        check("ovr_valid", valid1, 1);
        check("ovr_data_kept", data1, 8'h11);
        check("ovr_flag", ovr1, 1);
        ready1 = 1'b1;
        wait_cycles(1);
        ready1 = 1'b0;
        check("ovr_valid_cleared", valid1, 0);
        check("ovr_flag_cleared", ovr1, 0);
        check("ovr_q_empty", q1.size(), 0);
        ready1 = 1'b1;
        wait_cycles(CPB1);

        // Reset during data bit 3 of an all-ones frame.
        rx1 = 1'b0;
        wait_cycles(CPB1);
        rx1 = 1'b1;
        wait_cycles(3 * CPB1 + CPB1 / 2);
        check("pre_reset_busy", busy1, 1);
        rst_n = 1'b0;
        wait_cycles(3);
        check("midreset_outputs1", {data1, valid1, perr1, ferr1, ovr1, brk1, busy1}, 32'd0);
        rst_n = 1'b1;
        wait_cycles(10 * CPB1);
        check("no_partial_word", valid1, 0);
        q1.push_back('{data: 8'h7E, perr: 1'b0, ferr: 1'b0});
        send1(8'h7E, 1'b1);
        wait_cycles(2 * CPB1);
        check("7e_q_empty", q1.size(), 0);

        // Even parity, two stop bits.
        q2.push_back('{data: 8'h03, perr: 1'b1, ferr: 1'b0});
        send2(8'h03, 1'b1, 1'b1, 1'b1);
        q2.push_back('{data: 8'h03, perr: 1'b0, ferr: 1'b0});
        send2(8'h03, 1'b0, 1'b1, 1'b1);
        q2.push_back('{data: 8'h80, perr: 1'b0, ferr: 1'b1});
        send2(8'h80, 1'b1, 1'b1, 1'b0);
        rx2 = 1'b1;
        wait_cycles(2 * CPB2);
        q2.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0});
        send2(8'h5A, 1'b0, 1'b1, 1'b1);
        wait_cycles(2 * CPB2);
        check("dut2_q_empty", q2.size(), 0);
        check("dut2_no_break", brk_cnt2, 0);
        check("dut1_final_q_empty", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
